axi_adc_jesd204_capture_ctrl: RTL and testbench
===============================================

# axi_adc_jesd204_capture_ctrl

Capture sequencer for the JESD204 ADC receive path. Sits between the ADC core's per-channel valid outputs and the DMA: it arms on a control request, optionally waits for an external trigger and a programmable delay, aligns to a JESD frame boundary, and then passes exactly `ctrl_length` valid beats to the DMA before stopping. It reports busy, done, beat count and sticky overflow status for the register map.

## Interface
Parameters:
- `NUM_CHANNELS`, 1: number of converter channels; width of the enable and valid vectors.
- `LENGTH_WIDTH`, 16: width of the capture length and beat counter.
- `DELAY_WIDTH`, 8: width of the post-trigger delay counter.

Ports:
- `adc_clk` in 1: rx_clk domain clock, the only clock. All other signals are synchronous to it.
- `adc_rstn` in 1: reset. **Asynchronous assert, active-low.**
- `ctrl_arm` in 1: one-cycle pulse that starts a capture.
- `ctrl_abort` in 1: one-cycle pulse that cancels a capture.
- `ctrl_mode` in 1: trigger mode. 0 = immediate, 1 = external trigger.
- `ctrl_length` in LENGTH_WIDTH: number of beats to capture. Sampled on arm.
- `ctrl_delay` in DELAY_WIDTH: number of cycles to wait after the trigger. Sampled on arm.
- `trig_in` in 1: external trigger, already synchronous to `adc_clk`. Acts on its rising edge.
- `rx_sof` in 4: JESD start-of-frame per octet. Bit 0 marks a frame boundary beat.
- `adc_valid_in` in NUM_CHANNELS: per-channel valid from the ADC core.
- `adc_enable` in NUM_CHANNELS: per-channel enable from the ADC core.
- `adc_dovf` in 1: DMA overflow.
- `adc_valid_out` out NUM_CHANNELS: gated valid toward the DMA.
- `status_busy` out 1: high while a capture is in progress.
- `status_done` out 1: capture completed.
- `status_ovf` out 1: sticky overflow flag for the current capture.
- `status_count` out LENGTH_WIDTH: number of beats captured so far.

## Operation
States: IDLE, ARMED, DELAY, ALIGN, CAPTURE, DONE.

Transitions:
- IDLE or DONE on `ctrl_arm`:
  - Latch `ctrl_length`, `ctrl_delay` and `ctrl_mode`.
  - Clear `status_count`, `status_ovf` and `status_done`.
  - If the latched length is 0, go directly to DONE. Otherwise go to ARMED.
- ARMED:
  - Mode 0: go to DELAY on the next cycle.
  - Mode 1: go to DELAY on the cycle a `trig_in` rising edge is detected (`trig_in` high and its registered copy low).
  - `trig_in` held high at arm does not count as an edge.
- DELAY:
  - The delay counter loads the latched delay and decrements each cycle.
  - Go to ALIGN when the counter is 0. A delay of 0 means exactly one cycle spent in DELAY.
- ALIGN:
  - Wait for a cycle with `rx_sof[0]` high and `|adc_valid_in` high.
  - That beat is the first captured beat. Go to CAPTURE, or to DONE if the length is 1.
- CAPTURE:
  - Each cycle with `|adc_valid_in` is one beat and increments `status_count`.
  - The beat that makes `status_count` equal to the length moves the block to DONE.
- DONE:
  - `status_done` stays high until the next arm or abort.
- Any state on `ctrl_abort`: go to IDLE and clear `status_done`. `status_count` and `status_ovf` hold their values for software readout.

Outputs and flags:
- `adc_valid_out = adc_valid_in & adc_enable & {NUM_CHANNELS{window}}`.
- `window` is high when the state is CAPTURE, or the state is ALIGN with the qualifying SOF beat present.
- `status_busy` is high in ARMED, DELAY, ALIGN and CAPTURE.
- `status_ovf` is set by `adc_dovf` in ALIGN or CAPTURE, and holds until the next arm.

Boundary conditions:
- Arm while busy: ignored.
- Arm and abort in the same cycle: abort wins and the block goes to IDLE.
- The counter never wraps. The maximum length is 2^LENGTH_WIDTH−1.

## Timing
- **Reset values:**
  - State: IDLE.
  - `adc_valid_out`: 0.
  - `status_busy`, `status_done`, `status_ovf`: 0.
  - `status_count`: 0.
  - Trigger edge register: 0.
- `adc_valid_out` has zero latency: it is combinational from `adc_valid_in`, `adc_enable`, `rx_sof` and the state register. Data therefore needs no realignment.
- Arm in cycle N:
  - ARMED in N+1.
  - Mode 0 with delay 0: DELAY in N+2 and ALIGN in N+3.
- The trigger edge detected in cycle T gives DELAY in T+1.
- `status_count` updates one cycle after each beat.
- `status_done` rises one cycle after the final beat. The final beat itself still has `adc_valid_out` asserted; the next beat does not.
- Reset asserted mid-capture: outputs drop immediately (asynchronous), with no partial completion reported.

## Structure
- The shared package `axi_adc_jesd204_pkg` holds the state encoding localparams (3-bit, IDLE=0 … DONE=5) and the mode constants `MODE_IMMEDIATE` and `MODE_EXTERNAL`.
- One small sub-module, `axi_adc_jesd204_trig_edge`: a rising-edge detector with an async active-low reset. Everything else lives in the single FSM/counter module.

## Test plan
- Mode 0, length 8, delay 0, continuous valid, SOF every 4 cycles → exactly 8 `adc_valid_out` beats starting on the first SOF beat, `status_done`=1, `status_count`=8.
- Mode 1, delay 5, `trig_in` held high before arm and then pulsed → no start on the held level; capture begins in ALIGN ≥6 cycles after the real edge.
- Length 0 → DONE one cycle after arm, with no `adc_valid_out`. Length 1 → a single beat, then DONE.
- Gaps in `adc_valid_in` during CAPTURE, with `adc_enable`=2'b01 for NUM_CHANNELS=2 → only channel 0 is forwarded, the count skips the gaps, and the total is still 8.
- `adc_dovf` pulse in CAPTURE, then abort → `status_ovf`=1, `status_done`=0, state IDLE. A following arm clears `status_ovf`.
- Arm and abort in the same cycle, arm while busy, and reset mid-CAPTURE → stays IDLE; the busy arm is ignored; the reset forces all outputs to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/axi_adc_jesd204_pkg.sv
// Shared constants for the JESD204 ADC capture path: FSM state encoding and trigger modes.
package axi_adc_jesd204_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_DELAY   = 3'd2;
    localparam logic [2:0] ST_ALIGN   = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic MODE_IMMEDIATE = 1'b0;
    localparam logic MODE_EXTERNAL  = 1'b1;

endpackage

// File: rtl/axi_adc_jesd204_trig_edge.sv
// Rising-edge detector for a signal already synchronous to clk_i.
module axi_adc_jesd204_trig_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/axi_adc_jesd204_capture_ctrl.sv
// Capture sequencer: arm, optional trigger + delay, SOF alignment, then gate exactly
// ctrl_length valid beats toward the DMA.
module axi_adc_jesd204_capture_ctrl
    import axi_adc_jesd204_pkg::*;
#(
    parameter int NUM_CHANNELS = 1,
    parameter int LENGTH_WIDTH = 16,
    parameter int DELAY_WIDTH  = 8
) (
    input  logic                    adc_clk,
    input  logic                    adc_rstn,
    input  logic                    ctrl_arm,
    input  logic                    ctrl_abort,
    input  logic                    ctrl_mode,
    input  logic [LENGTH_WIDTH-1:0] ctrl_length,
    input  logic [DELAY_WIDTH-1:0]  ctrl_delay,
    input  logic                    trig_in,
    input  logic [3:0]              rx_sof,
    input  logic [NUM_CHANNELS-1:0] adc_valid_in,
    input  logic [NUM_CHANNELS-1:0] adc_enable,
    input  logic                    adc_dovf,
    output logic [NUM_CHANNELS-1:0] adc_valid_out,
    output logic                    status_busy,
    output logic                    status_done,
    output logic                    status_ovf,
    output logic [LENGTH_WIDTH-1:0] status_count
);

    logic [2:0]              state_q, state_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d;
    logic [DELAY_WIDTH-1:0]  dcnt_q, dcnt_d;
    logic                    mode_q, mode_d;
    logic [LENGTH_WIDTH-1:0] count_q, count_d;
    logic                    ovf_q, ovf_d;

    logic trig_rise;
    logic any_valid;
    logic sof_beat;
    logic window;
    logic unused_sof;

    axi_adc_jesd204_trig_edge u_trig_edge (
        .clk_i  (adc_clk),
        .rst_ni (adc_rstn),
        .sig_i  (trig_in),
        .rise_o (trig_rise)
    );

    // Only octet 0 carries the frame boundary we align to.
    assign unused_sof = ^rx_sof[3:1];
    assign any_valid  = |adc_valid_in;
    assign sof_beat   = rx_sof[0] & any_valid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        dcnt_d  = dcnt_q;
        mode_d  = mode_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (ctrl_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (ctrl_arm) begin
                        len_d   = ctrl_length;
                        dcnt_d  = ctrl_delay;
                        mode_d  = ctrl_mode;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = (ctrl_length == '0) ? ST_DONE : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (mode_q == MODE_IMMEDIATE || trig_rise) begin
                        state_d = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dcnt_q == '0) begin
                        state_d = ST_ALIGN;
                    end else begin
                        dcnt_d = dcnt_q - DELAY_WIDTH'(1);
                    end
                end
                ST_ALIGN: begin
                    if (adc_dovf) begin
                        ovf_d = 1'b1;
                    end
                    if (sof_beat) begin
                        count_d = LENGTH_WIDTH'(1);
                        state_d = (len_q == LENGTH_WIDTH'(1)) ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (adc_dovf) begin
                        ovf_d = 1'b1;
                    end
                    // count_q < len_q here, so the increment can never wrap.
                    if (any_valid) begin
                        count_d = count_q + LENGTH_WIDTH'(1);
                        if (count_d == len_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            dcnt_q  <= '0;
            mode_q  <= MODE_IMMEDIATE;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            dcnt_q  <= dcnt_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // The first aligned beat is forwarded in the same cycle it is recognised.
    assign window        = (state_q == ST_CAPTURE) || ((state_q == ST_ALIGN) && sof_beat);
    assign adc_valid_out = adc_valid_in & adc_enable & {NUM_CHANNELS{window}};

    assign status_busy  = (state_q == ST_ARMED) || (state_q == ST_DELAY) ||
                          (state_q == ST_ALIGN) || (state_q == ST_CAPTURE);
    assign status_done  = (state_q == ST_DONE);
    assign status_ovf   = ovf_q;
    assign status_count = count_q;

endmodule

// File: tb/tb_axi_adc_jesd204_capture_ctrl.sv
// Directed bench for the capture sequencer (two channels, 16-bit length, 8-bit delay).
module tb_axi_adc_jesd204_capture_ctrl;

    localparam int NC = 2;
    localparam int LW = 16;
    localparam int DW = 8;

    logic          adc_clk;
    logic          adc_rstn;
    logic          ctrl_arm;
    logic          ctrl_abort;
    logic          ctrl_mode;
    logic [LW-1:0] ctrl_length;
    logic [DW-1:0] ctrl_delay;
    logic          trig_in;
    logic [3:0]    rx_sof;
    logic [NC-1:0] adc_valid_in;
    logic [NC-1:0] adc_enable;
    logic          adc_dovf;
    logic [NC-1:0] adc_valid_out;
    logic          status_busy;
    logic          status_done;
    logic          status_ovf;
    logic [LW-1:0] status_count;

    int checks;
    int failures;
    int k;
    int sof_per;
    bit gap;
    int beats0, beats1;
    int first_cyc, last_cyc, done_cyc;
    bit first_sof;
    int arm_cyc, trig_cyc;

    axi_adc_jesd204_capture_ctrl #(
        .NUM_CHANNELS (NC),
        .LENGTH_WIDTH (LW),
        .DELAY_WIDTH  (DW)
    ) dut (
        .adc_clk       (adc_clk),
        .adc_rstn      (adc_rstn),
        .ctrl_arm      (ctrl_arm),
        .ctrl_abort    (ctrl_abort),
        .ctrl_mode     (ctrl_mode),
        .ctrl_length   (ctrl_length),
        .ctrl_delay    (ctrl_delay),
        .trig_in       (trig_in),
        .rx_sof        (rx_sof),
        .adc_valid_in  (adc_valid_in),
        .adc_enable    (adc_enable),
        .adc_dovf      (adc_dovf),
        .adc_valid_out (adc_valid_out),
        .status_busy   (status_busy),
        .status_done   (status_done),
        .status_ovf    (status_ovf),
        .status_count  (status_count)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        beats0    = 0;
        beats1    = 0;
        first_cyc = -1;
        last_cyc  = -1;
        done_cyc  = -1;
        first_sof = 1'b0;
    endtask

    // One clock cycle: drive SOF/valid patterns, observe mid-cycle, then advance.
    task automatic step();
        rx_sof       = {3'b000, ((k % sof_per) == 0)};
        adc_valid_in = (gap && (k % 3 == 2)) ? '0 : '1;
        #2;
        if (adc_valid_out[0]) begin
            beats0++;
            if (first_cyc < 0) begin
                first_cyc = k;
                first_sof = rx_sof[0];
            end
            last_cyc = k;
        end
        if (adc_valid_out[1]) beats1++;
        if (status_done && done_cyc < 0) done_cyc = k;
        @(posedge adc_clk);
        #1;
        ctrl_arm   = 1'b0;
        ctrl_abort = 1'b0;
        adc_dovf   = 1'b0;
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic arm(input logic mode, input int len, input int dly);
        ctrl_mode   = mode;
        ctrl_length = LW'(len);
        ctrl_delay  = DW'(dly);
        ctrl_arm    = 1'b1;
        arm_cyc     = k;
        clr_stats();
        step();
    endtask

    initial begin
        checks = 0; failures = 0; k = 0; sof_per = 1; gap = 1'b0;
        adc_rstn = 1'b0; ctrl_arm = 1'b0; ctrl_abort = 1'b0; ctrl_mode = 1'b0;
        ctrl_length = '0; ctrl_delay = '0; trig_in = 1'b0; rx_sof = 4'h1;
        adc_valid_in = '1; adc_enable = '1; adc_dovf = 1'b0;
        clr_stats();

        repeat (3) @(posedge adc_clk);
        #3;
        chk("rst_valid_out", 32'(adc_valid_out), 0);
        chk("rst_busy", 32'(status_busy), 0);
        chk("rst_done", 32'(status_done), 0);
        chk("rst_ovf", 32'(status_ovf), 0);
        chk("rst_count", 32'(status_count), 0);
        @(posedge adc_clk);
        #1;
        adc_rstn = 1'b1;

        // Mode 0, length 8, delay 0, SOF every 4 cycles.
        sof_per = 4;
        arm(1'b0, 8, 0);
        chk("m0_busy_after_arm", 32'(status_busy), 1);
        run(40);
        chk("m0_beats", 32'(beats0), 8);
        chk("m0_first_on_sof", 32'(first_sof), 1);
        chk("m0_done_lag", 32'(done_cyc - last_cyc), 1);
        chk("m0_done", 32'(status_done), 1);
        chk("m0_count", 32'(status_count), 8);
        chk("m0_busy_end", 32'(status_busy), 0);

        // Mode 1, delay 5: held trigger level must not start the capture.
        sof_per = 1;
        trig_in = 1'b1;
        run(3);
        arm(1'b1, 4, 5);
        run(10);
        chk("m1_held_no_beats", 32'(beats0), 0);
        chk("m1_held_busy", 32'(status_busy), 1);
        trig_in = 1'b0;
        step();
        trig_in  = 1'b1;
        trig_cyc = k;
        run(20);
        chk("m1_trig_to_beat", 32'(first_cyc - trig_cyc), 7);
        chk("m1_beats", 32'(beats0), 4);
        chk("m1_count", 32'(status_count), 4);
        trig_in = 1'b0;

        // Length 0 goes straight to DONE; length 1 yields a single beat.
        arm(1'b0, 0, 0);
        chk("len0_done", 32'(status_done), 1);
        chk("len0_busy", 32'(status_busy), 0);
        run(5);
        chk("len0_beats", 32'(beats0), 0);
        arm(1'b0, 1, 0);
        run(8);
        chk("len1_beats", 32'(beats0), 1);
        chk("len1_latency", 32'(first_cyc - arm_cyc), 3);
        chk("len1_done", 32'(status_done), 1);
        chk("len1_count", 32'(status_count), 1);

        // Valid gaps with only channel 0 enabled.
        sof_per    = 4;
        gap        = 1'b1;
        adc_enable = 2'b01;
        arm(1'b0, 8, 0);
        run(40);
        chk("gap_beats_ch0", 32'(beats0), 8);
        chk("gap_beats_ch1", 32'(beats1), 0);
        chk("gap_count", 32'(status_count), 8);
        chk("gap_done", 32'(status_done), 1);
        gap        = 1'b0;
        adc_enable = 2'b11;

        // Overflow during capture, then abort.
        sof_per = 1;
        arm(1'b0, 20, 0);
        run(6);
        adc_dovf = 1'b1;
        step();
        ctrl_abort = 1'b1;
        step();
        chk("abort_ovf", 32'(status_ovf), 1);
        chk("abort_done", 32'(status_done), 0);
        chk("abort_busy", 32'(status_busy), 0);
        chk("abort_count_held", 32'(status_count), 5);
        clr_stats();
        run(3);
        chk("abort_no_beats", 32'(beats0), 0);
        arm(1'b0, 2, 0);
        chk("rearm_ovf_clear", 32'(status_ovf), 0);
        run(8);
        chk("rearm_beats", 32'(beats0), 2);

        // Arm and abort together: abort wins.
        ctrl_abort = 1'b1;
        arm(1'b0, 4, 0);
        chk("arm_abort_busy", 32'(status_busy), 0);
        chk("arm_abort_done", 32'(status_done), 0);
        run(6);
        chk("arm_abort_beats", 32'(beats0), 0);

        // Arm while busy is ignored (length 0 would otherwise finish at once).
        arm(1'b1, 3, 0);
        arm(1'b0, 0, 0);
        chk("busy_arm_busy", 32'(status_busy), 1);
        chk("busy_arm_done", 32'(status_done), 0);
        ctrl_abort = 1'b1;
        step();

        // Asynchronous reset in the middle of a capture.
        arm(1'b0, 100, 0);
        run(6);
        adc_valid_in = '1;
        rx_sof       = 4'h1;
        #2;
        chk("pre_rst_valid_out", 32'(adc_valid_out), 3);
        adc_rstn = 1'b0;
        #1;
        chk("async_rst_valid_out", 32'(adc_valid_out), 0);
        chk("async_rst_busy", 32'(status_busy), 0);
        chk("async_rst_done", 32'(status_done), 0);
        chk("async_rst_count", 32'(status_count), 0);
        @(posedge adc_clk);
        #1;
        adc_rstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
